// File: rtl/control_path_pkg.sv
// control_path_pkg: opcode, sub-op, load-source, jump and run-state encodings for the flow CPU control path
package control_path_pkg;
  localparam logic [3:0] inst_null = 4'h0;
  localparam logic [3:0] inst_iadd = 4'h1;
  localparam logic [3:0] inst_unar = 4'hD;
  localparam logic [3:0] inst_incr = 4'hE;
  localparam logic [3:0] inst_jump = 4'hF;
  localparam logic [3:0] sub_ujmp = 4'h0;
  localparam logic [3:0] sub_swtr = 4'h1;
  localparam logic [3:0] sub_swcl = 4'h3;
  localparam logic [3:0] sub_plot = 4'h8;
  localparam logic [3:0] sub_vclr = 4'h9;
  localparam logic [3:0] sub_push = 4'hA;
  localparam logic [3:0] sub_pop  = 4'hB;
  localparam logic [3:0] sub_wmem = 4'hC;
  localparam logic [3:0] sub_rmem = 4'hD;
  typedef enum logic [1:0] {load_none = 2'b00, load_alu = 2'b01, load_mem = 2'b10, load_stk = 2'b11} load_src_e;
  typedef enum logic [1:0] {jmp_always = 2'b00, jmp_if_clear = 2'b01, jmp_if_set = 2'b10, jmp_never = 2'b11} jump_mode_e;
  typedef enum logic [1:0] {flg_zero = 2'b00, flg_sign = 2'b01, flg_overflow = 2'b10, flg_error = 2'b11} jump_flag_e;
  typedef enum logic [1:0] {st_run = 2'b00, st_stopped = 2'b01, st_armed = 2'b10} run_state_e;
  function automatic logic jump_taken(input logic [1:0] mode, input logic flag);
    return (mode == jmp_always) || (mode == jmp_if_clear && !flag) || (mode == jmp_if_set && flag);
  endfunction
endpackage

// File: rtl/control_path_run_stop_fsm.sv
// run_stop_fsm: RUN/STOPPED/ARMED sequencer; a halt stops the CPU, a press-and-release of the resume button restarts it
module run_stop_fsm
  import control_path_pkg::*;
(
  input  logic clock_i,
  input  logic reset_i,
  input  logic halt_i,
  input  logic user_clock_i,
  input  logic lock_i,
  output logic run_o,
  output logic switch_clock_o,
  output logic pc_inc_o
);
  run_state_e state_q, state_d;
  // state register, reset always lands in RUN
  always_ff @(posedge clock_i)
    state_q <= reset_i ? st_run : state_d;
  // next state: button press arms, release resumes; lock freezes both halted states
  always_comb begin
    state_d = state_q;
    case (state_q)
      st_run:     state_d = halt_i ? st_stopped : st_run;
      st_stopped: state_d = (!lock_i && !user_clock_i) ? st_armed : st_stopped;
      st_armed:   state_d = (!lock_i && user_clock_i) ? st_run : st_armed;
      default:    state_d = st_run;
    endcase
  end
  // outputs: PC advances only while running, switch_clock flags the halted states
  always_comb begin
    run_o = state_q == st_run;
    pc_inc_o = run_o;
    switch_clock_o = !run_o;
  end
endmodule

// File: rtl/control_path.sv
// control_path: instruction decoder and run/stop sequencer; CONTROL_PATH_CLOCK_LOCK_EN enables the clock_lock hold input
module control_path
  import control_path_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        user_clock,
  input  logic        clock_lock,
  input  logic [15:0] current_instruction,
  input  logic [15:0] switches,
  input  logic [15:0] zeroflag,
  input  logic [15:0] signflag,
  input  logic [15:0] overflow,
  input  logic [15:0] errorbit,
  output logic        program_counter_increment,
  output logic        switch_clock,
  output logic [3:0]  alu_op,
  output logic [15:0] alu_a_altern,
  output logic [15:0] alu_b_altern,
  output logic [3:0]  alu_a_select,
  output logic [3:0]  alu_b_select,
  output logic        alu_a_source,
  output logic        alu_b_source,
  output logic [3:0]  alu_out_select,
  output logic [1:0]  alu_load_src,
  output logic        alu_store_to_mem,
  output logic        alu_store_to_stk,
  output logic [3:0]  vga_color_select,
  output logic [3:0]  vga_coord_select,
  output logic        vga_plot,
  output logic        vga_resetn
);
  logic [3:0] op, f1, f2, f3;
  logic [15:0] flag_vec;
  logic run, lock, halt, flag_bit;
  assign {op, f1, f2, f3} = current_instruction;
  assign halt = (op == inst_null) && (f1 == sub_swcl);
  assign flag_vec = (f1[1:0] == flg_zero) ? zeroflag :
                    (f1[1:0] == flg_sign) ? signflag :
                    (f1[1:0] == flg_overflow) ? overflow : errorbit;
  assign flag_bit = flag_vec[f2];
`ifdef CONTROL_PATH_CLOCK_LOCK_EN
  assign lock = clock_lock;
`else
  logic unused_clock_lock;
  assign unused_clock_lock = clock_lock;
  assign lock = 1'b0;
`endif
  run_stop_fsm u_fsm (
    .clock_i        (clock),
    .reset_i        (reset),
    .halt_i         (halt),
    .user_clock_i   (user_clock),
    .lock_i         (lock),
    .run_o          (run),
    .switch_clock_o (switch_clock),
    .pc_inc_o       (program_counter_increment)
  );
  // decode strobes from the instruction, then mask side effects while halted
  always_comb begin
    alu_op = 4'h0;
    alu_a_altern = 16'h0;
    alu_b_altern = 16'h0;
    alu_a_select = 4'h0;
    alu_b_select = 4'h0;
    alu_a_source = 1'b0;
    alu_b_source = 1'b0;
    alu_out_select = 4'h0;
    alu_load_src = load_none;
    alu_store_to_mem = 1'b0;
    alu_store_to_stk = 1'b0;
    vga_color_select = 4'h0;
    vga_coord_select = 4'h0;
    vga_plot = 1'b0;
    vga_resetn = 1'b1;
    case (op)
      inst_null: begin
        alu_out_select = f2;
        alu_b_select = f3;
        case (f1)
          sub_swtr: begin
            alu_a_source = 1'b1;
            alu_a_altern = switches;
            alu_out_select = f3;
            alu_load_src = load_alu;
          end
          sub_plot: begin
            vga_color_select = f2;
            vga_coord_select = f3;
            vga_plot = 1'b1;
          end
          sub_vclr: vga_resetn = 1'b0;
          sub_push: alu_store_to_stk = 1'b1;
          sub_pop:  alu_load_src = load_stk;
          sub_wmem: begin
            alu_a_select = f2;
            alu_store_to_mem = 1'b1;
          end
          sub_rmem: alu_load_src = load_mem;
          default:  ;
        endcase
      end
      inst_incr: begin
        alu_op = inst_iadd;
        alu_a_select = f3;
        alu_out_select = f3;
        alu_b_source = 1'b1;
        alu_b_altern = {12'h0, f2};
        alu_load_src = load_alu;
      end
      inst_jump: begin
        alu_a_select = f3;
        alu_b_select = f2;
        alu_load_src = jump_taken(f1[3:2], flag_bit) ? load_alu : load_none;
      end
      default: begin
        alu_op = op;
        alu_a_select = f1;
        alu_b_select = f2;
        alu_out_select = f3;
        alu_load_src = load_alu;
      end
    endcase
    if (!run) begin
      alu_load_src = load_none;
      alu_store_to_mem = 1'b0;
      alu_store_to_stk = 1'b0;
      vga_plot = 1'b0;
    end
  end
endmodule

// File: tb/tb_control_path.sv
// tb_control_path: directed scoreboard bench for control_path
module tb_control_path;
  typedef struct packed {
    logic pci; logic swclk; logic [3:0] alu_op; logic [15:0] a_alt; logic [15:0] b_alt;
    logic [3:0] a_sel; logic [3:0] b_sel; logic a_src; logic b_src; logic [3:0] out_sel;
    logic [1:0] load; logic st_mem; logic st_stk; logic [3:0] color; logic [3:0] coord;
    logic plot; logic resetn;
  } outs_t;
`ifdef CONTROL_PATH_CLOCK_LOCK_EN
  localparam bit lock_en = 1'b1;
`else
  localparam bit lock_en = 1'b0;
`endif
  logic clock = 1'b0, reset, user_clock, clock_lock;
  logic [15:0] current_instruction, switches, zeroflag, signflag, overflow, errorbit;
  logic program_counter_increment, switch_clock, alu_a_source, alu_b_source;
  logic alu_store_to_mem, alu_store_to_stk, vga_plot, vga_resetn;
  logic [3:0] alu_op, alu_a_select, alu_b_select, alu_out_select, vga_color_select, vga_coord_select;
  logic [15:0] alu_a_altern, alu_b_altern;
  logic [1:0] alu_load_src;
  outs_t got, e;
  outs_t exp_q[$];
  string tag_q[$];
  int vectors = 0, miscompares = 0;
  always #5 clock = ~clock;
  control_path dut (
    .clock(clock), .reset(reset), .user_clock(user_clock), .clock_lock(clock_lock),
    .current_instruction(current_instruction), .switches(switches),
    .zeroflag(zeroflag), .signflag(signflag), .overflow(overflow), .errorbit(errorbit),
    .program_counter_increment(program_counter_increment), .switch_clock(switch_clock),
    .alu_op(alu_op), .alu_a_altern(alu_a_altern), .alu_b_altern(alu_b_altern),
    .alu_a_select(alu_a_select), .alu_b_select(alu_b_select),
    .alu_a_source(alu_a_source), .alu_b_source(alu_b_source),
    .alu_out_select(alu_out_select), .alu_load_src(alu_load_src),
    .alu_store_to_mem(alu_store_to_mem), .alu_store_to_stk(alu_store_to_stk),
    .vga_color_select(vga_color_select), .vga_coord_select(vga_coord_select),
    .vga_plot(vga_plot), .vga_resetn(vga_resetn)
  );
  assign got = {program_counter_increment, switch_clock, alu_op, alu_a_altern, alu_b_altern,
                alu_a_select, alu_b_select, alu_a_source, alu_b_source, alu_out_select,
                alu_load_src, alu_store_to_mem, alu_store_to_stk, vga_color_select,
                vga_coord_select, vga_plot, vga_resetn};
  function automatic outs_t base(input bit run);
    outs_t o = '0;
    o.pci = run;
    o.swclk = !run;
    o.resetn = 1'b1;
    return o;
  endfunction
  function automatic outs_t alu3125(input bit run);
    outs_t o = base(run);
    o.alu_op = 4'h3; o.a_sel = 4'h1; o.b_sel = 4'h2; o.out_sel = 4'h5; o.load = run ? 2'b01 : 2'b00;
    return o;
  endfunction
  function automatic outs_t swtr(input bit run);
    outs_t o = base(run);
    o.a_src = 1'b1; o.a_alt = 16'h1567; o.b_sel = 4'h5; o.out_sel = 4'h5; o.load = run ? 2'b01 : 2'b00;
    return o;
  endfunction
  function automatic outs_t push34(input bit run);
    outs_t o = base(run);
    o.out_sel = 4'h3; o.b_sel = 4'h4; o.st_stk = run;
    return o;
  endfunction
  task automatic nxt();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input outs_t x);
    outs_t ex;
    string t;
    exp_q.push_back(x);
    tag_q.push_back(tag);
    @(negedge clock);
    ex = exp_q.pop_front();
    t = tag_q.pop_front();
    vectors++;
    assert (got === ex) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", t, got, ex);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1);
  end
  initial begin
    reset = 1'b1; user_clock = 1'b1; clock_lock = 1'b0; current_instruction = 16'h0000;
    switches = 16'h0; zeroflag = 16'h0; signflag = 16'h0; overflow = 16'h0; errorbit = 16'h0;
    nxt(); chk("reset", base(1));
    nxt(); reset = 1'b0; current_instruction = 16'hE066;
    e = base(1); e.alu_op = 4'h1; e.a_sel = 4'h6; e.out_sel = 4'h6; e.b_src = 1'b1; e.b_alt = 16'h0006; e.load = 2'b01;
    chk("incr", e);
    nxt(); current_instruction = 16'h3125; chk("alu3", alu3125(1));
    nxt(); current_instruction = 16'hD7A9;
    e = base(1); e.alu_op = 4'hD; e.a_sel = 4'h7; e.b_sel = 4'hA; e.out_sel = 4'h9; e.load = 2'b01;
    chk("unar", e);
    nxt(); current_instruction = 16'h0823;
    e = base(1); e.out_sel = 4'h2; e.b_sel = 4'h3; e.color = 4'h2; e.coord = 4'h3; e.plot = 1'b1;
    chk("plot", e);
    nxt(); current_instruction = 16'h0900;
    e = base(1); e.resetn = 1'b0; chk("vclr", e);
    nxt(); current_instruction = 16'h0A34; chk("push", push34(1));
    nxt(); current_instruction = 16'h0B34;
    e = base(1); e.out_sel = 4'h3; e.b_sel = 4'h4; e.load = 2'b11; chk("pop", e);
    nxt(); current_instruction = 16'h0D34;
    e = base(1); e.out_sel = 4'h3; e.b_sel = 4'h4; e.load = 2'b10; chk("rmem", e);
    nxt(); current_instruction = 16'h0C56;
    e = base(1); e.a_sel = 4'h5; e.b_sel = 4'h6; e.out_sel = 4'h5; e.st_mem = 1'b1; chk("wmem", e);
    nxt(); current_instruction = 16'h0234;
    e = base(1); e.out_sel = 4'h3; e.b_sel = 4'h4; chk("subop_nop", e);
    nxt(); current_instruction = 16'hF457;
    e = base(1); e.a_sel = 4'h7; e.b_sel = 4'h5; e.load = 2'b01; chk("jnz_taken", e);
    nxt(); zeroflag = 16'h0020; e.load = 2'b00; chk("jnz_not_taken", e);
    nxt(); current_instruction = 16'hF012;
    e = base(1); e.a_sel = 4'h2; e.b_sel = 4'h1; e.load = 2'b01; chk("jump_always", e);
    nxt(); current_instruction = 16'hFC12; e.load = 2'b00; chk("jump_never", e);
    nxt(); current_instruction = 16'hF935; signflag = 16'h0008;
    e = base(1); e.a_sel = 4'h5; e.b_sel = 4'h3; e.load = 2'b01; chk("js_taken", e);
    nxt(); signflag = 16'h0000; e.load = 2'b00; chk("js_not_taken", e);
    nxt(); current_instruction = 16'hF735; errorbit = 16'h0008; chk("jne_err_set", e);
    nxt(); current_instruction = 16'hF635; e.load = 2'b01; chk("jno_ovf_clear", e);
    nxt(); current_instruction = 16'h0300; chk("swcl_run", base(1));
    nxt(); current_instruction = 16'h0105; switches = 16'h1567; chk("swtr_stopped", swtr(0));
    nxt(); user_clock = 1'b0; chk("press", swtr(0));
    nxt(); user_clock = 1'b1; chk("release", swtr(0));
    nxt(); chk("resumed_swtr", swtr(1));
    nxt(); current_instruction = 16'h0300; chk("swcl2_run", base(1));
    nxt(); current_instruction = 16'h0A34; chk("push_stopped", push34(0));
    nxt(); current_instruction = 16'h0823;
    e = base(0); e.out_sel = 4'h2; e.b_sel = 4'h3; e.color = 4'h2; e.coord = 4'h3; chk("plot_stopped", e);
    nxt(); reset = 1'b1; current_instruction = 16'h0A34; chk("reset_driven_stopped", push34(0));
    nxt(); reset = 1'b0; chk("reset_resumes", push34(1));
    nxt(); current_instruction = 16'h0300; chk("swcl3_run", base(1));
    nxt(); current_instruction = 16'h3125; clock_lock = 1'b1; chk("lock_stopped", alu3125(0));
    nxt(); user_clock = 1'b0; chk("lock_press", alu3125(0));
    nxt(); user_clock = 1'b1; chk("lock_release", alu3125(0));
    nxt(); chk("lock_hold1", alu3125(!lock_en));
    nxt(); chk("lock_hold2", alu3125(!lock_en));
    nxt(); clock_lock = 1'b0; user_clock = 1'b0; chk("unlock_press", alu3125(!lock_en));
    nxt(); user_clock = 1'b1; chk("unlock_release", alu3125(!lock_en));
    nxt(); chk("unlock_resumed", alu3125(1));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/control_path.md
Name: control_path

Overview:
- Instruction decoder and run/stop sequencer for the 16-bit flow CPU.
- Decodes the current 16-bit instruction into ALU, register-file, memory/stack and VGA control strobes.
- Gates program-counter advance.
- Lets the user halt execution (SWCL) and resume it with a push-button (user_clock).

Parameters:
- none (all widths fixed at 16-bit data, 16 registers).

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- user_clock  in  1  resume button, active-low (pressed = 0).
- clock_lock  in  1  1 = hold the block in STOPPED and ignore user_clock.
- current_instruction  in  16  {op[15:12], f1[11:8], f2[7:4], f3[3:0]}.
- switches  in  16  board switches.
- zeroflag, signflag, overflow, errorbit  in  16 each  per-register flags; bit i belongs to register i.
- program_counter_increment  out  1  1 = PC advances this cycle.
- switch_clock  out  1  1 while STOPPED/ARMED.
- alu_op  out  4  ALU operation; 0 = LEFT (pass A).
- alu_a_altern, alu_b_altern  out  16  immediate operands.
- alu_a_select, alu_b_select  out  4  register-file read addresses.
- alu_a_source, alu_b_source  out  1  1 = use altern, 0 = use register.
- alu_out_select  out  4  write-back register.
- alu_load_src  out  2  00 none, 01 ALU result, 10 memory, 11 stack.
- alu_store_to_mem, alu_store_to_stk  out  1  store strobes.
- vga_color_select, vga_coord_select  out  4  VGA operand registers.
- vga_plot  out  1  plot strobe.
- vga_resetn  out  1  active-low VGA clear.

Behaviour:
- Decode is combinational from current_instruction and run state.
- Default for every output: 0, except vga_resetn = 1.
- State machine, reset → RUN:
  - RUN: executing SWCL → STOPPED.
  - STOPPED: user_clock = 0 → ARMED.
  - ARMED: user_clock = 1 → RUN.
  - clock_lock = 1 holds STOPPED/ARMED.
- In STOPPED/ARMED:
  - load_src = 00, both stores = 0, vga_plot = 0, program_counter_increment = 0, switch_clock = 1.
  - Select and altern outputs still follow decode.
- In RUN: program_counter_increment = 1, switch_clock = 0.
- Opcodes 1–C and D (IADD..ISHL, UNAR):
  - alu_op = op; a_select = f1; b_select = f2; out_select = f3; load_src = 01.
- Opcode E, INCR imm dst:
  - alu_op = 1 (IADD); a_select = out_select = f3; b_source = 1; b_altern = zero-extended f2; load_src = 01.
- Opcode F, JUMP:
  - f1[3:2] mode: 00 always, 01 if flag clear, 10 if flag set, 11 never.
  - f1[1:0] flag: 00 zero, 01 sign, 10 overflow, 11 error; the flag bit is indexed by f2.
  - alu_op = 0; a_select = f3; b_select = f2; out_select = 0 (PC register).
  - load_src = 01 when the condition is true, else 00.
- Opcode 0, NULL; sub-op = f1; in every sub-op alu_op = 0, out_select = f2, and b_select = f3 unless stated:
  - 0 UJMP (no-op).
  - 1 SWTR: a_source = 1, a_altern = switches, b_select = f3, out_select = f3, load 01.
  - 3 SWCL: halt, no load.
  - 8 PLOT: color_select = f2, coord_select = f3, vga_plot = 1.
  - 9 VCLR: vga_resetn = 0.
  - A PUSH: store_to_stk = 1.
  - B POP: load 11.
  - C WMEM: a_select = f2, b_select = f3, store_to_mem = 1, load 00.
  - D RMEM: load 10.
  - Other sub-ops are no-ops.
- Reset forces RUN. A reset mid-halt resumes immediately.

Optional Feature:
- Macro: CONTROL_PATH_CLOCK_LOCK_EN.
- Defined: clock_lock is honoured as above.
- Undefined: clock_lock is ignored; the user_clock pulse alone resumes.

Decomposition:
- control_path_pkg: opcode constants (inst_null..inst_jump), NULL sub-op codes, load_src encodings, jump mode/flag encodings, state enum.
- One sub-module, run_stop_fsm: RUN/STOPPED/ARMED and switch_clock/program_counter_increment generation. Decode stays in control_path.

Test Plan:
- INCR 0 6 6 in RUN → alu_op = 1, out_select = 6, load = 01, a_source = 0, b_source = 1, b_altern = 0006, no stores.
- SWCL, then SWTR LEFT 5 while stopped → load = 00, no stores. Pulse user_clock low then high, switches = 1567 → alu_op = 0, load = 01, a_altern = 1567, a_source = 1, b_select = 5, out_select = 5.
- WMEM 5 6 (0x0C56) → store_to_mem = 1, load = 00, out_select = 5, both sources register.
- JUMP D-JNZ 5 7 (0xF457): zeroflag[5] = 0 → load = 01, out_select = 0. zeroflag[5] = 1 → load = 00.
- Reset asserted while STOPPED → next cycle RUN, program_counter_increment = 1.
- clock_lock = 1 during a user_clock pulse (feature enabled) → remains stopped, load = 00.
